// File: rtl/gx_rx_frame_parser.sv
// Receive-side frame parser: hunts for SYNC_WORD, then reads a length word, LEN payload
// words and a checksum word. Payload is forwarded downstream; each frame ends in frame_ok or frame_err.
module gx_rx_frame_parser #(
    parameter logic [15:0] SYNC_WORD = 16'hEB90,
    parameter int unsigned MAX_LEN   = 64,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] rx_data,
    input  logic        rx_valid,
    output logic [15:0] pld_data,
    output logic        pld_valid,
    output logic        pld_sof,
    output logic        pld_eof,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt
);

    localparam int unsigned DW = 16;
    localparam int unsigned CW = 10;
    localparam int unsigned IW = 16;

    typedef enum logic [1:0] {ST_HUNT, ST_LEN, ST_DATA, ST_CHK} state_t;

    state_t        state;
    logic [CW-1:0] word_cnt;
    logic [IW-1:0] idle_cnt;
    logic [DW-1:0] csum;
    logic          first;

    logic len_bad_c;
    logic chk_good_c;
    logic chk_bad_c;
    logic timeout_c;
    logic err_next_c;

    // Frame decisions taken on the current edge; they become the registered pulses.
    always_comb begin
        len_bad_c  = 1'b0;
        chk_good_c = 1'b0;
        chk_bad_c  = 1'b0;
        timeout_c  = 1'b0;
        if (rx_valid) begin
            if (state == ST_LEN)
                len_bad_c = (rx_data == '0) || (rx_data > DW'(MAX_LEN));
            if (state == ST_CHK) begin
                chk_good_c = (rx_data == csum);
                chk_bad_c  = (rx_data != csum);
            end
        end else if (state != ST_HUNT) begin
            timeout_c = (idle_cnt == IW'(TIMEOUT - 1));
        end
        err_next_c = len_bad_c | chk_bad_c | timeout_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_HUNT;
            word_cnt  <= '0;
            idle_cnt  <= '0;
            csum      <= '0;
            first     <= 1'b0;
            pld_data  <= '0;
            pld_valid <= 1'b0;
            pld_sof   <= 1'b0;
            pld_eof   <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            pld_valid <= 1'b0;
            pld_sof   <= 1'b0;
            pld_eof   <= 1'b0;
            frame_ok  <= chk_good_c;
            frame_err <= err_next_c;

            if (chk_good_c && (frame_cnt != 16'hFFFF))
                frame_cnt <= frame_cnt + 16'd1;
            if (err_next_c && (err_cnt != 16'hFFFF))
                err_cnt <= err_cnt + 16'd1;

            if (!rx_valid) begin
                // Idle only matters while a frame is open; expiry drops back to hunting.
                if (state != ST_HUNT) begin
                    if (timeout_c) begin
                        state    <= ST_HUNT;
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + IW'(1);
                    end
                end
            end else begin
                idle_cnt <= '0;
                unique case (state)
                    ST_HUNT: begin
                        if (rx_data == SYNC_WORD)
                            state <= ST_LEN;
                    end
                    ST_LEN: begin
                        if (len_bad_c) begin
                            state <= ST_HUNT;
                        end else begin
                            word_cnt <= CW'(rx_data);
                            csum     <= rx_data;
                            first    <= 1'b1;
                            state    <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        pld_valid <= 1'b1;
                        pld_data  <= rx_data;
                        pld_sof   <= first;
                        pld_eof   <= (word_cnt == CW'(1));
                        first     <= 1'b0;
                        csum      <= csum + rx_data;
                        word_cnt  <= word_cnt - CW'(1);
                        if (word_cnt == CW'(1))
                            state <= ST_CHK;
                    end
                    ST_CHK: begin
                        state <= ST_HUNT;
                    end
                    default: state <= ST_HUNT;
                endcase
            end
        end
    end

endmodule
